display_scan_ctrl: RTL

Sequencing controller for the seven-segment readout path. It generates the periodic load enable for the input register and captures the registered binary value. It converts that value to BCD with a multi-cycle shift-add-3 FSM, then time-multiplexes the BCD digits onto shared segment lines with active-low anode selects. It replaces the free-running refresh/toggle logic between the gray-to-binary decoder and the segment decoders.

---
 rtl/display_pkg.sv | 25 ++
 rtl/bin2bcd_seq.sv | 64 ++++++
 rtl/display_scan_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    CONVERT,
    LATCH
  } state_t;

  // Dash/error code shown on every digit while the value is out of range.
  localparam logic [3:0] BCD_ERR = 4'hF;

  // Four BCD nibbles hold the widest supported input (10 bits -> 1023).
  localparam int unsigned BCD_NIB = 4;

  // Ceiling log2 with a floor of one bit, used to size counters.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((32'd1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one input bit per cycle.
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     bin,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  over
);

  localparam int unsigned ITER_W = clog2(DATA_W);

  logic [DATA_W-1:0]    shift;
  logic [4*BCD_NIB-1:0] acc;
  logic [4*BCD_NIB-1:0] adj;
  logic [ITER_W-1:0]    iter;
  logic                 running;

  assign done = running && (iter == ITER_W'(DATA_W - 1));
  assign bcd  = acc[4*DIGITS-1:0];

  // Add-3 correction on every nibble of 5 or more, ahead of the shift.
  always_comb begin
    adj = acc;
    for (int unsigned i = 0; i < BCD_NIB; i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  // Any nonzero nibble beyond the displayed digits means the value cannot be shown.
  always_comb begin
    over = 1'b0;
    for (int unsigned i = DIGITS; i < BCD_NIB; i++) begin
      if (acc[4*i +: 4] != 4'd0) over = 1'b1;
    end
  end

  // Load on start, then shift one binary bit into the accumulator per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift   <= '0;
      acc     <= '0;
      iter    <= '0;
      running <= 1'b0;
    end else if (start) begin
      shift   <= bin;
      acc     <= '0;
      iter    <= '0;
      running <= 1'b1;
    end else if (running) begin
      acc   <= (adj << 1) | {{(4*BCD_NIB-1){1'b0}}, shift[DATA_W-1]};
      shift <= shift << 1;
      iter  <= iter + 1'b1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Sample sequencing, BCD conversion control and multiplexed digit drive.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 25_000_000,
  parameter int unsigned SCAN_DIV   = 50_000,
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned DIGITS     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] bin_in,
  input  logic              lz_blank_en,
  output logic              sample_en,
  output logic [3:0]        digit_code,
  output logic [DIGITS-1:0] digit_sel,
  output logic              blank,
  output logic              busy,
  output logic              overflow
);

  localparam int unsigned SAMPLE_W = clog2(SAMPLE_DIV);
  localparam int unsigned SCAN_W   = clog2(SCAN_DIV);
  localparam int unsigned IDX_W    = clog2(DIGITS);

  state_t                  state;
  logic [SAMPLE_W-1:0]     sample_cnt;
  logic [SCAN_W-1:0]       scan_cnt;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_next;
  logic [DIGITS-1:0][3:0]  disp_buf;
  logic [DIGITS-1:0][3:0]  buf_next;
  logic                    ovf_next;
  logic                    sample_pre;
  logic                    sample_wrap;
  logic                    scan_wrap;
  logic                    conv_start;
  logic                    conv_done;
  logic                    conv_over;
  logic [4*DIGITS-1:0]     conv_bcd;
  logic                    upper_zero;
  logic [3:0]              code_next;
  logic [DIGITS-1:0]       sel_next;
  logic                    blank_next;

  // sample_en is registered, so the tick is decoded one count early.
  assign sample_pre  = (sample_cnt == SAMPLE_W'(SAMPLE_DIV - 2));
  assign sample_wrap = (sample_cnt == SAMPLE_W'(SAMPLE_DIV - 1));
  assign scan_wrap   = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign conv_start  = (state == CAPTURE);

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (bin_in),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .over  (conv_over)
  );

  // Free-running sample prescaler.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sample_cnt <= '0;
    else      sample_cnt <= sample_wrap ? '0 : sample_cnt + 1'b1;
  end

  // Free-running scan prescaler.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) scan_cnt <= '0;
    else      scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
  end

  // Capture/convert/latch sequencer; a tick arriving while busy is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sample_en <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sample_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sample_en) begin
            state <= CAPTURE;
            busy  <= 1'b1;
          end else begin
            sample_en <= sample_pre;
          end
        end
        CAPTURE: state <= CONVERT;
        CONVERT: if (conv_done) state <= LATCH;
        LATCH: begin
          state     <= IDLE;
          busy      <= 1'b0;
          sample_en <= sample_pre;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Next display state and pad values, built from next-cycle register contents
  // so the registered pads change in the same cycle as the buffer and index.
  always_comb begin
    buf_next = disp_buf;
    ovf_next = overflow;
    if (state == LATCH) begin
      buf_next = conv_bcd;
      ovf_next = conv_over;
    end
    idx_next = idx;
    if (scan_wrap) idx_next = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
    upper_zero = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if ((IDX_W'(i) >= idx_next) && (buf_next[i] != 4'd0)) upper_zero = 1'b0;
    end
    sel_next   = ~(DIGITS'(1) << idx_next);
    code_next  = buf_next[idx_next];
    blank_next = 1'b0;
    if (ovf_next) begin
      code_next = BCD_ERR;
    end else if (lz_blank_en && (idx_next != '0) && upper_zero) begin
      blank_next = 1'b1;
      sel_next   = '1;
      code_next  = '0;
    end
  end

  // Display buffer, scan index, overflow flag and registered pad outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_buf   <= '0;
      idx        <= '0;
      overflow   <= 1'b0;
      digit_code <= '0;
      digit_sel  <= ~DIGITS'(1);
      blank      <= 1'b0;
    end else begin
      disp_buf   <= buf_next;
      idx        <= idx_next;
      overflow   <= ovf_next;
      digit_code <= code_next;
      digit_sel  <= sel_next;
      blank      <= blank_next;
    end
  end

endmodule
